demux_stream: RTL and testbench
===============================

# demux_stream

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshaking, per-channel one-word output slots, a broadcast mode and a saturating drop counter for out-of-range selects. It is the buffered successor of the combinational 1-to-8 demux. It sits between a single producer and N independent consumers, and lets each consumer stall without blocking traffic to the others.

## Interface
Parameters:
- N_CH, default 8: number of output channels, 2..16; any value is legal, not only powers of two.
- DATA_W, default 8: data width in bits, 1..64.
- SEL_W: localparam, $clog2(N_CH); width of the channel select.
- CNT_W, default 8: width of the drop counter.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid & s_ready.
- s_data  in  DATA_W  input word.
- s_sel  in  SEL_W  destination channel.
- s_bcast  in  1  broadcast: write the word to every channel; s_sel is ignored.
- m_valid  out  N_CH  per-channel slot valid.
- m_ready  in  N_CH  per-channel consumer ready.
- m_data  out  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- drop_cnt  out  CNT_W  count of words dropped because s_sel >= N_CH; saturates.

## Operation
- Each channel k has one slot holding a data register and a valid flag.
- Slot k is free when m_valid[k]==0 or m_ready[k]==1. The second case is draining this cycle, so that slot can be popped and refilled in the same cycle.
- s_ready is combinational from registered state and m_ready only. It does not depend on s_valid.
  - s_bcast==1: s_ready = all slots free.
  - s_bcast==0 and s_sel < N_CH: s_ready = slot[s_sel] free.
  - s_bcast==0 and s_sel >= N_CH: s_ready = 1. The word is accepted and discarded, and drop_cnt increments unless it is already at 2^CNT_W-1.
- Accept in unicast mode: slot[s_sel] loads s_data and m_valid[s_sel] is set.
- Accept in broadcast mode: every slot loads s_data and every m_valid bit is set.
- Pop: when m_valid[k] & m_ready[k] and there is no simultaneous load of slot k, m_valid[k] clears and m_data[k] clears to 0.
- Simultaneous pop and load on the same slot: the new word replaces the old one and m_valid[k] stays 1.
- Idle channels always drive m_data = 0. This keeps the zero-on-unselected-output behaviour of the combinational demux.
- Channels are independent. A stalled channel never blocks unicast traffic to any other channel.
- A producer must hold s_valid, s_data, s_sel and s_bcast stable until it sees s_ready. If it does not, behaviour is undefined, but there is no corruption of other slots.

## Timing
- Reset state, asynchronous and immediate: m_valid=0, m_data=0, drop_cnt=0. s_ready follows its combinational rule on the reset state, i.e. 1, but no accept is registered while rst=1.
- Reset deasserted mid-stream: all buffered words are lost. The first accept can happen in the first clk edge with rst low.
- Latency: a word accepted at edge t appears on m_valid/m_data right after edge t, so a consumer can take it at edge t+1.
- Throughput: one word per cycle into any channel whose consumer holds m_ready=1, including back-to-back words into the same channel.
- Broadcast waits for the slowest slot. Partial broadcasts never occur.
- drop_cnt updates on the accept edge and holds at its maximum value once saturated.

## Test plan
- Reset: drive rst=1 mid-operation with slots 2 and 5 full -> m_valid=0x00, all m_data=0 and drop_cnt=0 asynchronously, before the next clk edge.
- Unicast streaming: N_CH=8, DATA_W=8, m_ready=0xFF, send 0x11..0x18 to sel=0..7 on consecutive cycles -> each channel k shows 0x11+k for exactly one cycle, 1 cycle after its accept; s_ready is held at 1 throughout.
- Back-pressure isolation: m_ready[3]=0 and slot 3 full. Send to sel=3, then sel=4 -> s_ready=0 for the sel=3 word. Once the producer moves to sel=4 its word is accepted, and ch3 keeps its old data. Raising m_ready[3] frees slot 3 and lets the next sel=3 word be accepted.
- Same-cycle pop and push: ch1 holds 0xAA with m_ready[1]=1, and 0xBB is sent to sel=1 -> m_valid[1] stays 1 and m_data[1]=0xBB the next cycle.
- Broadcast: send 0x5C with s_bcast=1 while m_ready[6]=0 and slot 6 full -> s_ready=0 until ch6 pops. Then all 8 channels show 0x5C in the same cycle.
- Out-of-range drop: N_CH=6, CNT_W=2, send 5 words with sel=7 -> all are accepted and no m_valid rises. drop_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/demux_stream.sv
// Registered 1-to-N stream demultiplexer: one output slot per channel, broadcast
// mode, and a saturating counter of words dropped for out-of-range selects.
module demux_stream #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic [SEL_W-1:0]         s_sel,
  input  logic                     s_bcast,
  output logic [N_CH-1:0]          m_valid,
  input  logic [N_CH-1:0]          m_ready,
  output logic [N_CH*DATA_W-1:0]   m_data,
  output logic [CNT_W-1:0]         drop_cnt
);
  localparam int SEL_N = 1 << SEL_W;

  logic [N_CH-1:0]             r_valid;
  logic [N_CH-1:0][DATA_W-1:0] r_data;
  logic [CNT_W-1:0]            r_drop;

  logic [SEL_N-1:0] w_free;
  logic [N_CH-1:0]  w_load;
  logic             w_in_range;
  logic             w_acc;
  logic             w_drop;

  // Free-vector padded to the full select range so any s_sel indexes safely.
  always_comb begin
    w_free            = '0;
    w_free[N_CH-1:0]  = ~r_valid | m_ready;
  end

  assign w_in_range = 32'(s_sel) < N_CH;
  assign s_ready    = s_bcast    ? &w_free[N_CH-1:0] :
                      w_in_range ? w_free[s_sel]     : 1'b1;
  assign w_acc      = s_valid & s_ready;
  assign w_drop     = w_acc & ~s_bcast & ~w_in_range;

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    assign w_load[k] = w_acc & (s_bcast | (32'(s_sel) == k));

    // A load wins over a pop, so a draining slot is refilled in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
      end else if (w_load[k]) begin
        r_valid[k] <= 1'b1;
        r_data[k]  <= s_data;
      end else if (r_valid[k] && m_ready[k]) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_drop <= '0;
    else if (w_drop && r_drop != {CNT_W{1'b1}})
      r_drop <= r_drop + CNT_W'(1);
  end

  assign m_valid  = r_valid;
  assign m_data   = r_data;
  assign drop_cnt = r_drop;
endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: slot-level model checked every cycle on an 8-channel
// instance, plus directed literal checks and a 6-channel drop-counter instance.
module tb_demux_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // 8-channel instance
  logic        s_valid = 1'b0, s_bcast = 1'b0, s_ready;
  logic [7:0]  s_data = '0;
  logic [2:0]  s_sel = '0;
  logic [7:0]  m_valid, m_ready = 8'hFF;
  logic [63:0] m_data;
  logic [7:0]  drop_cnt;

  // 6-channel instance with a 2-bit drop counter
  logic        b_valid = 1'b0, b_ready;
  logic [7:0]  b_data = '0;
  logic [2:0]  b_sel = '0;
  logic [5:0]  b_mvalid;
  logic [47:0] b_mdata;
  logic [1:0]  b_drop;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  demux_stream #(.N_CH(8), .DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sel(s_sel), .s_bcast(s_bcast), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .drop_cnt(drop_cnt));

  demux_stream #(.N_CH(6), .DATA_W(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
    .s_sel(b_sel), .s_bcast(1'b0), .m_valid(b_mvalid), .m_ready(6'h3F),
    .m_data(b_mdata), .drop_cnt(b_drop));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one word per channel ----------------
  logic [7:0] ev;
  logic [7:0] ed [8];
  int         ecnt;
  bit         acc;

  function automatic logic model_ready();
    if (s_bcast) return (~ev | m_ready) == 8'hFF;
    if (s_sel < 8) return !ev[s_sel] || m_ready[s_sel];
    return 1'b1;
  endfunction

  function automatic logic [63:0] model_data();
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = ed[k];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ev = '0;
      for (int k = 0; k < 8; k++) ed[k] = '0;
      ecnt = 0;
    end else begin
      acc = s_valid && model_ready();
      for (int k = 0; k < 8; k++)
        if (ev[k] && m_ready[k]) begin ev[k] = 1'b0; ed[k] = '0; end
      if (acc) begin
        if (s_bcast)
          for (int k = 0; k < 8; k++) begin ev[k] = 1'b1; ed[k] = s_data; end
        else if (s_sel < 8) begin
          ev[s_sel] = 1'b1; ed[s_sel] = s_data;
        end else if (ecnt != 255) ecnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("mdl_s_ready", 64'(s_ready), 64'(model_ready()));
      chk("mdl_m_valid", 64'(m_valid), 64'(ev));
      chk("mdl_m_data", m_data, model_data());
      chk("mdl_drop_cnt", 64'(drop_cnt), 64'(ecnt));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input logic [2:0] sel, input logic [7:0] d, input logic bc);
    int n = 0;
    s_valid = 1'b1; s_sel = sel; s_data = d; s_bcast = bc;
    @(negedge clk);
    while (!s_ready && n < 50) begin n++; @(negedge clk); end
    if (!s_ready) chk("send_timeout", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_bcast = 1'b0;
  endtask

  int exp_b [5] = '{1, 2, 3, 3, 3};

  initial begin
    #2;
    chk("rst_m_valid", 64'(m_valid), 64'h0);
    chk("rst_m_data", m_data, 64'h0);
    chk("rst_drop", 64'(drop_cnt), 64'h0);
    chk("rst_s_ready", 64'(s_ready), 64'h1);
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b0; chk_en = 1'b1;

    // unicast streaming: each word visible for exactly one cycle
    for (int k = 0; k < 8; k++) begin
      send(3'(k), 8'h11 + 8'(k), 1'b0);
      chk("uni_valid", 64'(m_valid), 64'(8'h01 << k));
      chk("uni_data", 64'(m_data[k*8 +: 8]), 64'(8'h11 + 8'(k)));
    end
    @(posedge clk); #1;
    chk("uni_drained", 64'(m_valid), 64'h0);

    // back-pressure isolation on channel 3
    m_ready[3] = 1'b0;
    send(3'd3, 8'h33, 1'b0);
    s_valid = 1'b1; s_sel = 3'd3; s_data = 8'h34;
    @(negedge clk);
    chk("bp_ready_lo", 64'(s_ready), 64'h0);
    @(posedge clk); #1;
    send(3'd4, 8'h44, 1'b0);
    chk("bp_ch3_hold", 64'(m_data[31:24]), 64'h33);
    chk("bp_ch4", 64'(m_data[39:32]), 64'h44);
    m_ready[3] = 1'b1;
    send(3'd3, 8'h35, 1'b0);
    chk("bp_ch3_new", 64'(m_data[31:24]), 64'h35);

    // same-cycle pop and push on channel 1
    m_ready[1] = 1'b0;
    send(3'd1, 8'hAA, 1'b0);
    m_ready[1] = 1'b1;
    send(3'd1, 8'hBB, 1'b0);
    chk("pp_valid", 64'(m_valid[1]), 64'h1);
    chk("pp_data", 64'(m_data[15:8]), 64'hBB);

    // broadcast blocked by a full, stalled channel 6
    m_ready[6] = 1'b0;
    send(3'd6, 8'h66, 1'b0);
    s_valid = 1'b1; s_bcast = 1'b1; s_data = 8'h5C; s_sel = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bc_ready_lo", 64'(s_ready), 64'h0);
    end
    @(posedge clk); #1;
    chk("bc_no_partial", 64'(m_data[55:48]), 64'h66);
    m_ready[6] = 1'b1;
    send(3'd0, 8'h5C, 1'b1);
    chk("bc_valid", 64'(m_valid), 64'hFF);
    chk("bc_data", m_data, {8{8'h5C}});
    @(posedge clk); #1;

    // asynchronous reset mid-stream with slots 2 and 5 full
    m_ready = 8'hDB;
    send(3'd2, 8'h22, 1'b0);
    send(3'd5, 8'h55, 1'b0);
    chk("pre_rst_valid", 64'(m_valid), 64'h24);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(m_valid), 64'h0);
    chk("async_rst_data", m_data, 64'h0);
    chk("async_rst_drop", 64'(drop_cnt), 64'h0);
    @(posedge clk); #3 rst = 1'b0;
    m_ready = 8'hFF;
    @(posedge clk); #1;

    // out-of-range drops on the 6-channel instance
    for (int i = 0; i < 5; i++) begin
      b_valid = 1'b1; b_sel = 3'd7; b_data = 8'(8'hD0 + i);
      @(negedge clk);
      chk("drop_ready", 64'(b_ready), 64'h1);
      @(posedge clk); #1;
      chk("drop_cnt", 64'(b_drop), 64'(exp_b[i]));
      chk("drop_no_valid", 64'(b_mvalid), 64'h0);
    end
    b_valid = 1'b0;
    @(posedge clk); #1;
    chk("drop_hold", 64'(b_drop), 64'h3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
